fetch_pipe: RTL

Pipelined fetch stage for the Y86-64 core: owns the F register (predicted PC), selects the fetch PC, reads and decodes instruction bytes from a byte-addressed instruction memory, predicts the next PC and loads the F/D pipeline register consumed by decode. It sits upstream of decode/write-back. It takes stall/bubble controls from the hazard unit and misprediction/return information from the M and W stages.

---
 rtl/fetch_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_pipe.sv
// fetch_pipe: Y86-64 fetch stage.
//   Owns predPC, selects the fetch PC, reads and decodes up to ten bytes
//   from a byte-addressed instruction memory, predicts the next PC and
//   loads the F/D pipeline register.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   imem_we/waddr/wdata           program-load byte write port
//   F_stall, D_stall, D_bubble    hazard-unit controls
//   M_icode, M_cnd, M_valA        mispredicted-branch redirect from M
//   W_icode, W_valM               ret redirect from W
//   f_pc                          selected fetch PC (combinational)
//   D_stat .. D_valP              F/D pipeline register outputs
module fetch_pipe #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] f_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    logic [7:0]  mem [MEM_SIZE];
    logic [63:0] pred_pc;

    logic [7:0]  fb [10];
    logic [3:0]  icode, ifun, f_icode, f_ifun, ra, rb, len;
    logic        need_regids, need_valc, imem_error, instr_invalid;
    logic [63:0] valc, valp, next_pred;
    logic [64:0] last_addr;
    stat_t       f_stat;

    // Program load; out-of-range writes are dropped. No reset on contents.
    always_ff @(posedge clk) begin
        if (imem_we && imem_waddr < 64'(MEM_SIZE))
            mem[imem_waddr[AW-1:0]] <= imem_wdata;
    end

    always_comb begin
        if (M_icode == 4'h7 && !M_cnd)
            f_pc = M_valA;
        else if (W_icode == 4'h9)
            f_pc = W_valM;
        else
            f_pc = pred_pc;
    end

    // Bytes beyond the array read as zero.
    always_comb begin
        for (int unsigned k = 0; k < 10; k++) begin
            fb[k] = '0;
            if (f_pc + 64'(k) < 64'(MEM_SIZE))
                fb[k] = mem[AW'(f_pc + 64'(k))];
        end
    end

    always_comb begin
        icode = fb[0][7:4];
        ifun  = fb[0][3:0];

        need_regids = 1'b0;
        need_valc   = 1'b0;
        len         = 4'd1;
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin need_regids = 1'b1; len = 4'd2; end
            4'h3, 4'h4, 4'h5:       begin need_regids = 1'b1; need_valc = 1'b1; len = 4'd10; end
            4'h7, 4'h8:             begin need_valc = 1'b1; len = 4'd9; end
            default:                len = 4'd1;
        endcase

        ra = need_regids ? fb[1][7:4] : 4'hF;
        rb = need_regids ? fb[1][3:0] : 4'hF;

        valc = '0;
        if (need_valc) begin
            for (int unsigned k = 0; k < 8; k++)
                valc[8*k +: 8] = need_regids ? fb[k+2] : fb[k+1];
        end

        valp = f_pc + 64'(len);

        // 65-bit sum so a wrap past 2^64 also lands beyond MEM_SIZE.
        last_addr     = {1'b0, f_pc} + 65'(len) - 65'd1;
        imem_error    = last_addr >= 65'(MEM_SIZE);
        instr_invalid = icode > 4'hB;

        f_icode = icode;
        f_ifun  = ifun;
        if (imem_error) begin
            f_stat  = STAT_ADR;
            f_icode = 4'h1;
            f_ifun  = 4'h0;
        end else if (instr_invalid) begin
            f_stat = STAT_INS;
        end else if (icode == 4'h0) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end

        next_pred = (icode == 4'h7 || icode == 4'h8) ? valc : valp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pred_pc <= RESET_PC;
        else if (!F_stall)
            pred_pc <= next_pred;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (D_bubble && !D_stall)) begin
            D_stat  <= STAT_AOK;
            D_icode <= 4'h1;
            D_ifun  <= 4'h0;
            D_rA    <= 4'hF;
            D_rB    <= 4'hF;
            D_valC  <= '0;
            D_valP  <= '0;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= ra;
            D_rB    <= rb;
            D_valC  <= valc;
            D_valP  <= valp;
        end
    end

endmodule
